// File: rtl/warp_fetcher_if.sv
// Fetch-side and program-memory-side signals of the warp fetcher.
// master: the fetcher (drives instruction_ready/instruction and the memory read request).
// slave : the environment (scheduler drives fetch_req/warp_id/pc/flush, memory drives ready/data).
interface warp_fetcher_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int WARP_BITS = 8
);
  logic                 fetch_req;
  logic [WARP_BITS-1:0] warp_id;
  logic [ADDR_BITS-1:0] pc;
  logic                 flush;
  logic                 instruction_ready;
  logic [DATA_BITS-1:0] instruction;
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (
    input  fetch_req, warp_id, pc, flush, mem_read_ready, mem_read_data,
    output instruction_ready, instruction, mem_read_valid, mem_read_address
  );

  modport slave (
    output fetch_req, warp_id, pc, flush, mem_read_ready, mem_read_data,
    input  instruction_ready, instruction, mem_read_valid, mem_read_address
  );
endinterface

// File: rtl/warp_fetcher.sv
// Instruction-fetch responder with a one-entry instruction buffer per warp.
// Latency: buffer hit 1 cycle; miss 1 cycle after mem_read_ready is sampled (min 2 cycles).
// Backpressure: mem_read_valid held with a stable address until mem_read_ready; instruction_ready held until fetch_req drops.
// Ports: clk, reset (sync, active-low), bus (warp_fetcher_if.master: scheduler fetch side + program memory read side).
module warp_fetcher #(
  parameter int MAX_WARPS             = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic            clk,
  input  logic            reset,
  warp_fetcher_if.master  bus
);
  localparam int WARP_BITS = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUESTING = 2'd1,
    DELIVER    = 2'd2
  } state_t;

  state_t                           state;
  logic [WARP_BITS-1:0]             lat_warp;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] lat_pc;

  logic                             buf_valid [MAX_WARPS];
  logic [PROGRAM_MEM_ADDR_BITS-1:0] buf_pc    [MAX_WARPS];
  logic [PROGRAM_MEM_DATA_BITS-1:0] buf_instr [MAX_WARPS];

  logic                             lookup_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] lookup_instr;

  // Lookup against the live request; warp ids beyond the table never match any entry.
  always_comb begin
    lookup_hit   = 1'b0;
    lookup_instr = '0;
    for (int i = 0; i < MAX_WARPS; i++) begin
      if (bus.warp_id == WARP_BITS'(i) && buf_valid[i] && buf_pc[i] == bus.pc) begin
        lookup_hit   = 1'b1;
        lookup_instr = buf_instr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                 <= IDLE;
      lat_warp              <= '0;
      lat_pc                <= '0;
      bus.instruction_ready <= 1'b0;
      bus.instruction       <= '0;
      bus.mem_read_valid    <= 1'b0;
      bus.mem_read_address  <= '0;
      for (int i = 0; i < MAX_WARPS; i++) begin
        buf_valid[i] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.fetch_req) begin
            lat_warp <= bus.warp_id;
            lat_pc   <= bus.pc;
            if (lookup_hit) begin
              bus.instruction       <= lookup_instr;
              bus.instruction_ready <= 1'b1;
              state                 <= DELIVER;
            end else begin
              bus.mem_read_valid   <= 1'b1;
              bus.mem_read_address <= bus.pc;
              state                <= REQUESTING;
            end
          end
        end

        REQUESTING: begin
          if (bus.mem_read_ready) begin
            bus.mem_read_valid <= 1'b0;
            bus.instruction    <= bus.mem_read_data;
            for (int i = 0; i < MAX_WARPS; i++) begin
              if (lat_warp == WARP_BITS'(i)) begin
                buf_valid[i] <= 1'b1;
                buf_pc[i]    <= lat_pc;
                buf_instr[i] <= bus.mem_read_data;
              end
            end
            // A scheduler that left its fetch phase gets no ready pulse; the fill still lands.
            if (bus.fetch_req) begin
              bus.instruction_ready <= 1'b1;
              state                 <= DELIVER;
            end else begin
              state <= IDLE;
            end
          end
        end

        DELIVER: begin
          if (!bus.fetch_req) begin
            bus.instruction_ready <= 1'b0;
            state                 <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Placed after the fill so a coincident flush leaves the entry invalid.
      if (bus.flush) begin
        for (int i = 0; i < MAX_WARPS; i++) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_warp_fetcher.sv
module tb_warp_fetcher;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  warp_fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16), .WARP_BITS(8)) bus ();

  warp_fetcher #(
    .MAX_WARPS(4),
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: what each warp's buffer entry should hold.
  bit          m_valid [4];
  logic [7:0]  m_pc    [4];
  logic [15:0] m_instr [4];

  // Scoreboard queues: expected delivered instructions and expected memory read addresses.
  logic [15:0] exp_instr [$];
  logic [7:0]  exp_addr  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_flush();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT raises ready or starts a memory read.
  initial begin
    logic        prev_rdy = 1'b0;
    logic        prev_vld = 1'b0;
    logic [15:0] held_instr = '0;
    logic [7:0]  held_addr = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_rdy = 1'b0;
        prev_vld = 1'b0;
      end else begin
        if (bus.instruction_ready === 1'b1 && !prev_rdy) begin
          if (exp_instr.size() == 0) begin
            chk("unexpected_ready", 32'(bus.instruction_ready), 32'd0);
          end else begin
            held_instr = exp_instr.pop_front();
            chk("instr", 32'(bus.instruction), 32'(held_instr));
          end
        end else if (bus.instruction_ready === 1'b1) begin
          chk("instr_hold", 32'(bus.instruction), 32'(held_instr));
        end
        if (bus.mem_read_valid === 1'b1 && !prev_vld) begin
          if (exp_addr.size() == 0) begin
            chk("unexpected_read", 32'(bus.mem_read_valid), 32'd0);
          end else begin
            held_addr = exp_addr.pop_front();
            chk("rd_addr", 32'(bus.mem_read_address), 32'(held_addr));
          end
        end else if (bus.mem_read_valid === 1'b1) begin
          chk("rd_addr_hold", 32'(bus.mem_read_address), 32'(held_addr));
        end
        prev_rdy = (bus.instruction_ready === 1'b1);
        prev_vld = (bus.mem_read_valid === 1'b1);
      end
    end
  end

  task automatic deliver_and_drop();
    int k;
    k = $urandom_range(0, 2);
    repeat (k) begin
      bus.pc      = 8'($urandom);
      bus.warp_id = 8'($urandom);
      tick();
      chk("rdy_held", 32'(bus.instruction_ready), 32'd1);
    end
    bus.fetch_req = 1'b0;
    tick();
    chk("rdy_drop", 32'(bus.instruction_ready), 32'd0);
  endtask

  task automatic fetch(input logic [7:0] w, input logic [7:0] p, input int wait_cyc,
                       input logic [15:0] data, input bit abandon, input bit flush_req,
                       input bit flush_fill);
    bit hit;
    hit = 1'b0;
    if (w < 8'd4) hit = m_valid[w[1:0]] && (m_pc[w[1:0]] == p);
    bus.fetch_req = 1'b1;
    bus.warp_id   = w;
    bus.pc        = p;
    bus.flush     = flush_req;
    if (hit) exp_instr.push_back(m_instr[w[1:0]]);
    else     exp_addr.push_back(p);
    if (flush_req) model_flush();
    tick();
    bus.flush = 1'b0;
    if (hit) begin
      chk("hit_rdy", 32'(bus.instruction_ready), 32'd1);
      chk("hit_no_read", 32'(bus.mem_read_valid), 32'd0);
      deliver_and_drop();
    end else begin
      chk("miss_read", 32'(bus.mem_read_valid), 32'd1);
      chk("miss_rdy_early", 32'(bus.instruction_ready), 32'd0);
      repeat (wait_cyc) begin
        bus.pc      = 8'($urandom);
        bus.warp_id = 8'($urandom);
        if ($urandom_range(0, 3) == 0) bus.fetch_req = ~bus.fetch_req;
        tick();
        chk("read_held", 32'(bus.mem_read_valid), 32'd1);
        chk("rdy_wait", 32'(bus.instruction_ready), 32'd0);
      end
      bus.mem_read_ready = 1'b1;
      bus.mem_read_data  = data;
      bus.flush          = flush_fill;
      bus.fetch_req      = !abandon;
      if (!abandon) exp_instr.push_back(data);
      if (w < 8'd4) begin
        m_valid[w[1:0]] = 1'b1;
        m_pc[w[1:0]]    = p;
        m_instr[w[1:0]] = data;
      end
      if (flush_fill) model_flush();
      tick();
      bus.mem_read_ready = 1'b0;
      bus.mem_read_data  = 16'($urandom);
      bus.flush          = 1'b0;
      chk("read_done", 32'(bus.mem_read_valid), 32'd0);
      if (abandon) begin
        chk("abandon_no_rdy", 32'(bus.instruction_ready), 32'd0);
      end else begin
        chk("miss_rdy", 32'(bus.instruction_ready), 32'd1);
        deliver_and_drop();
      end
    end
  endtask

  initial begin
    bus.fetch_req      = 1'b0;
    bus.warp_id        = '0;
    bus.pc             = '0;
    bus.flush          = 1'b0;
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = '0;
    model_flush();
    repeat (3) tick();
    reset = 1'b1;
    chk("rst_rdy", 32'(bus.instruction_ready), 32'd0);
    chk("rst_instr", 32'(bus.instruction), 32'd0);
    chk("rst_rvalid", 32'(bus.mem_read_valid), 32'd0);
    chk("rst_raddr", 32'(bus.mem_read_address), 32'd0);
    tick();

    // First miss, then a hit on the same PC, then a miss on a new PC for the same warp.
    fetch(8'd0, 8'h00, 2, 16'h5A3C, 1'b0, 1'b0, 1'b0);
    fetch(8'd0, 8'h00, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
    fetch(8'd0, 8'h01, 1, 16'hBEEF, 1'b0, 1'b0, 1'b0);

    // Fill all four warps, refetch round-robin, then an out-of-range warp.
    for (int i = 0; i < 4; i++) fetch(8'(i), 8'(4 * (i + 1)), i, 16'(16'h1000 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) fetch(8'(i), 8'(4 * (i + 1)), 0, 16'h0000, 1'b0, 1'b0, 1'b0);
    fetch(8'd5, 8'h04, 0, 16'h5555, 1'b0, 1'b0, 1'b0);
    fetch(8'd5, 8'h04, 1, 16'h5556, 1'b0, 1'b0, 1'b0);

    // Abandoned fetch still fills the buffer.
    fetch(8'd1, 8'h20, 2, 16'h1111, 1'b1, 1'b0, 1'b0);
    fetch(8'd1, 8'h20, 0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Flush coinciding with a fill: delivered, but the entry ends invalid.
    fetch(8'd2, 8'h40, 1, 16'h2222, 1'b0, 1'b0, 1'b1);
    fetch(8'd2, 8'h40, 0, 16'h2223, 1'b0, 1'b0, 1'b0);

    // Reset while REQUESTING.
    bus.fetch_req = 1'b1;
    bus.warp_id   = 8'd3;
    bus.pc        = 8'hEE;
    exp_addr.push_back(8'hEE);
    tick();
    chk("pre_rst_read", 32'(bus.mem_read_valid), 32'd1);
    tick();
    reset         = 1'b0;
    bus.fetch_req = 1'b0;
    tick();
    reset = 1'b1;
    model_flush();
    chk("mid_rst_rdy", 32'(bus.instruction_ready), 32'd0);
    chk("mid_rst_instr", 32'(bus.instruction), 32'd0);
    chk("mid_rst_rvalid", 32'(bus.mem_read_valid), 32'd0);
    chk("mid_rst_raddr", 32'(bus.mem_read_address), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) fetch(8'(i), 8'(4 * (i + 1)), 0, 16'(16'h3000 + i), 1'b0, 1'b0, 1'b0);

    // Randomized traffic over a small PC set so hits are frequent.
    for (int n = 0; n < 200; n++) begin
      fetch(8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)), $urandom_range(0, 3),
            16'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 9) == 0));
    end

    repeat (3) tick();
    chk("instr_queue_empty", 32'(exp_instr.size()), 32'd0);
    chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
